// File: rtl/codec_cfg_seq.sv
// rtl/codec_cfg_seq.sv - WM8731 power-up register sequencer over the 2-wire control bus (optional macro: CODEC_CFG_RETRY_EN)
module codec_cfg_seq #(
    parameter int          CLK_DIV  = 125,
    parameter logic [6:0]  DEV_ADDR = 7'h1A
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic [2:0] cur_index,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_FIN, S_ERR
    } state_t;

    state_t           r_state, w_state_nx;
    logic [DIV_W-1:0] r_div, w_div_nx;
    logic [1:0]       r_phase, w_phase_nx;
    logic [2:0]       r_bit_cnt, w_bit_nx;
    logic [1:0]       r_byte_cnt, w_byte_nx;
    logic [7:0]       r_shift, w_shift_nx;
    logic [1:0]       r_gap_cnt, w_gap_nx;
    logic [2:0]       r_index, w_index_nx;
    logic             r_nack, w_nack_nx;
    logic             r_ack_smp, w_ack_smp_nx;
    logic             r_busy, r_done, r_ack_error, r_scl_oe, r_sda_oe;
    logic             w_tick, w_period_end;
`ifdef CODEC_CFG_RETRY_EN
    logic [1:0]       r_retry, w_retry_nx;
`endif

    // {register address[6:0], data[8:0]} for each table entry
    function automatic logic [15:0] table_entry(input logic [2:0] idx);
        logic [15:0] ent;
        case (idx)
            3'd0:    ent = {7'd15, 9'h000};
            3'd1:    ent = {7'd6,  9'h000};
            3'd2:    ent = {7'd4,  9'h012};
            3'd3:    ent = {7'd5,  9'h000};
            3'd4:    ent = {7'd7,  9'h00A};
            3'd5:    ent = {7'd8,  9'h000};
            3'd6:    ent = {7'd2,  9'h079};
            default: ent = {7'd9,  9'h001};
        endcase
        return ent;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [1:0] sel);
        logic [15:0] ent;
        logic [7:0]  b;
        ent = table_entry(idx);
        case (sel)
            2'd0:    b = {DEV_ADDR, 1'b0};
            2'd1:    b = ent[15:8];
            default: b = ent[7:0];
        endcase
        return b;
    endfunction

    // {scl_oe, sda_oe} for a given state, quarter-bit phase and data bit
    function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] ph, input logic bit_v);
        logic [1:0] d;
        case (st)
            S_START: d = {ph[1], (ph != 2'd0)};
            S_BIT:   d = {~ph[1], ~bit_v};
            S_ACK:   d = {~ph[1], 1'b0};
            S_STOP:  d = {~ph[1], (ph != 2'd3)};
            default: d = 2'b00;
        endcase
        return d;
    endfunction

    assign w_tick       = r_busy && (r_div == DIV_LAST);
    assign w_period_end = w_tick && (r_phase == 2'd3);

    // Next-state logic: divider, phase, bit/byte counters and frame sequencing
    always_comb begin
        w_state_nx   = r_state;
        w_div_nx     = r_busy ? (w_tick ? '0 : r_div + DIV_ONE) : '0;
        w_phase_nx   = w_tick ? r_phase + 2'd1 : r_phase;
        w_bit_nx     = r_bit_cnt;
        w_byte_nx    = r_byte_cnt;
        w_shift_nx   = r_shift;
        w_gap_nx     = r_gap_cnt;
        w_index_nx   = r_index;
        w_nack_nx    = r_nack;
        w_ack_smp_nx = r_ack_smp;
`ifdef CODEC_CFG_RETRY_EN
        w_retry_nx   = r_retry;
`endif
        case (r_state)
            S_IDLE, S_FIN, S_ERR: begin
                if (start) begin
                    w_state_nx = S_START;
                    w_phase_nx = 2'd0;
                    w_index_nx = 3'd0;
                    w_nack_nx  = 1'b0;
`ifdef CODEC_CFG_RETRY_EN
                    w_retry_nx = 2'd0;
`endif
                end
            end
            S_START: begin
                if (w_period_end) begin
                    w_state_nx = S_BIT;
                    w_byte_nx  = 2'd0;
                    w_bit_nx   = 3'd0;
                    w_shift_nx = frame_byte(r_index, 2'd0);
                end
            end
            S_BIT: begin
                if (w_period_end) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nx = S_ACK;
                    end else begin
                        w_bit_nx   = r_bit_cnt + 3'd1;
                        w_shift_nx = {r_shift[6:0], 1'b0};
                    end
                end
            end
            S_ACK: begin
                // sample while SCL is high, on the last cycle of phase 2
                if (w_tick && (r_phase == 2'd2)) begin
                    w_ack_smp_nx = sda_in;
                end
                if (w_period_end) begin
                    if (r_ack_smp) begin
                        w_state_nx = S_STOP;
                        w_nack_nx  = 1'b1;
                    end else if (r_byte_cnt == 2'd2) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_state_nx = S_BIT;
                        w_byte_nx  = r_byte_cnt + 2'd1;
                        w_bit_nx   = 3'd0;
                        w_shift_nx = frame_byte(r_index, r_byte_cnt + 2'd1);
                    end
                end
            end
            S_STOP: begin
                if (w_period_end) begin
                    w_gap_nx = 2'd0;
                    if (!r_nack) begin
                        w_state_nx = S_GAP;
                    end else begin
`ifdef CODEC_CFG_RETRY_EN
                        if (r_retry != 2'd3) begin
                            w_state_nx = S_GAP;
                            w_retry_nx = r_retry + 2'd1;
                        end else begin
                            w_state_nx = S_ERR;
                        end
`else
                        w_state_nx = S_ERR;
`endif
                    end
                end
            end
            S_GAP: begin
                if (w_period_end) begin
                    if (r_gap_cnt != 2'd3) begin
                        w_gap_nx = r_gap_cnt + 2'd1;
                    end else if (r_nack) begin
                        // resend the same entry after a NACK
                        w_state_nx = S_START;
                        w_nack_nx  = 1'b0;
                    end else if (r_index == 3'd7) begin
                        w_state_nx = S_FIN;
                    end else begin
                        w_state_nx = S_START;
                        w_index_nx = r_index + 3'd1;
`ifdef CODEC_CFG_RETRY_EN
                        w_retry_nx = 2'd0;
`endif
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register; status and pad enables are registered from the next state so the pads never glitch
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_phase     <= 2'd0;
            r_bit_cnt   <= 3'd0;
            r_byte_cnt  <= 2'd0;
            r_shift     <= 8'd0;
            r_gap_cnt   <= 2'd0;
            r_index     <= 3'd0;
            r_nack      <= 1'b0;
            r_ack_smp   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ack_error <= 1'b0;
            r_scl_oe    <= 1'b0;
            r_sda_oe    <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
            r_retry     <= 2'd0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_div       <= w_div_nx;
            r_phase     <= w_phase_nx;
            r_bit_cnt   <= w_bit_nx;
            r_byte_cnt  <= w_byte_nx;
            r_shift     <= w_shift_nx;
            r_gap_cnt   <= w_gap_nx;
            r_index     <= w_index_nx;
            r_nack      <= w_nack_nx;
            r_ack_smp   <= w_ack_smp_nx;
            r_busy      <= (w_state_nx != S_IDLE) && (w_state_nx != S_FIN) && (w_state_nx != S_ERR);
            r_done      <= (w_state_nx == S_FIN);
            r_ack_error <= (w_state_nx == S_ERR);
            {r_scl_oe, r_sda_oe} <= line_drive(w_state_nx, w_phase_nx, w_shift_nx[7]);
`ifdef CODEC_CFG_RETRY_EN
            r_retry     <= w_retry_nx;
`endif
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign ack_error = r_ack_error;
    assign cur_index = r_index;
    assign scl_oe    = r_scl_oe;
    assign sda_oe    = r_sda_oe;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb/tb_codec_cfg_seq.sv - randomized self-checking bench for codec_cfg_seq with a bus-level slave model
module tb_codec_cfg_seq;

    localparam int CLK_DIV = 2;
    localparam int PER_CYC = 4 * CLK_DIV;
`ifdef CODEC_CFG_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       start   = 1'b0;
    logic       busy, done, ack_error, scl_oe, sda_oe, sda_in;
    logic [2:0] cur_index;
    logic       slave_pull = 1'b0;

    assign sda_in = ~sda_oe & ~slave_pull;

    codec_cfg_seq #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h1A)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error),
        .cur_index (cur_index),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .sda_in    (sda_in)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int tbl_addr[8] = '{15, 6, 4, 5, 7, 8, 2, 9};
    int tbl_data[8] = '{'h000, 'h000, 'h012, 'h000, 'h00A, 'h000, 'h079, 'h001};

    // slave NACK policy, owned by the stimulus process
    int nack_lo = 0;
    int nack_k  = 0;
    int nack_b  = 0;

    // bus slave: decodes START/STOP and bytes from the pad lines, ACKs unless policy says NACK
    logic        prev_scl = 1'b1, prev_sda = 1'b1;
    bit          have_frame = 0, collecting = 0, ack_phase = 0;
    int          bit_cnt = 0, byte_idx = 0, f_cnt = 0, stop_cnt = 0;
    logic [7:0]  shreg = 8'd0;
    logic [23:0] cur_bytes = 24'd0;
    logic [23:0] fr_data[$];
    int          fr_len[$];

    always @(negedge sys_clk) begin : slave_model
        logic scl, sda;
        scl = ~scl_oe;
        sda = ~sda_oe;
        if (prev_scl && scl && prev_sda && !sda) begin
            f_cnt++;
            have_frame = 1; collecting = 1; ack_phase = 0;
            bit_cnt = 0; byte_idx = 0; cur_bytes = 24'd0; slave_pull = 1'b0;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            if (have_frame) begin
                fr_data.push_back(cur_bytes);
                fr_len.push_back(byte_idx);
            end
            stop_cnt++;
            have_frame = 0; collecting = 0; ack_phase = 0; slave_pull = 1'b0;
        end else if (!prev_scl && scl && collecting && !ack_phase && bit_cnt < 8) begin
            shreg = {shreg[6:0], sda};
            bit_cnt++;
        end else if (prev_scl && !scl && collecting) begin
            if (ack_phase) begin
                ack_phase = 0; slave_pull = 1'b0; bit_cnt = 0;
            end else if (bit_cnt == 8) begin
                cur_bytes = {cur_bytes[15:0], shreg};
                byte_idx++;
                ack_phase = 1;
                if ((f_cnt - 1) >= nack_lo && (f_cnt - 1) < nack_lo + nack_k && (byte_idx - 1) == nack_b) begin
                    slave_pull = 1'b0;
                    collecting = 0;
                end else begin
                    slave_pull = 1'b1;
                end
            end
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    // one full start->done/ack_error run; frames with ordinal e..e+k-1 NACKed on byte b
    task automatic run_case(input string name, input int e, input int b, input int k, input bit extra);
        int          base_q, base_s, cyc, exp_cyc, f, idx, retries, periods, len, extra_at, nfr;
        bit          err, timeout, nk;
        int          exp_idx[$];
        int          exp_len[$];
        logic [23:0] full, expv;
        logic [6:0]  a;
        logic [8:0]  d;

        f = 0; idx = 0; retries = 0; periods = 0; err = 0;
        while (idx < 8 && !err) begin
            nk  = (f >= e) && (f < e + k);
            len = nk ? b + 1 : 3;
            exp_idx.push_back(idx);
            exp_len.push_back(len);
            periods += 2 + 9 * len;
            f++;
            if (nk) begin
                if (RETRY_EN && retries < 3) begin
                    retries++;
                    periods += 4;
                end else begin
                    err = 1;
                end
            end else begin
                periods += 4;
                idx++;
                retries = 0;
            end
        end
        exp_cyc = periods * PER_CYC;

        base_q  = fr_data.size();
        base_s  = stop_cnt;
        nack_lo = f_cnt + e;
        nack_b  = b;
        nack_k  = k;
        extra_at = $urandom_range(10, 2000);

        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        check({name, ":busy_rise"}, busy, 1);
        cyc = 0;
        timeout = 1;
        while (cyc < 6000) begin
            start = extra && (cyc == extra_at);
            @(negedge sys_clk);
            cyc++;
            if (done || ack_error) begin
                timeout = 0;
                break;
            end
        end
        start = 1'b0;
        check({name, ":timeout"}, timeout, 0);
        check({name, ":cycles"}, cyc, exp_cyc);
        check({name, ":done"}, done, !err);
        check({name, ":ack_error"}, ack_error, err);
        check({name, ":busy_end"}, busy, 0);
        check({name, ":cur_index"}, cur_index, err ? idx : 7);
        repeat (6) @(negedge sys_clk);
        check({name, ":held"}, {done, ack_error, busy, scl_oe, sda_oe}, {!err, err, 3'b000});

        nfr = fr_data.size() - base_q;
        check({name, ":frames"}, nfr, exp_idx.size());
        check({name, ":stops"}, stop_cnt - base_s, exp_idx.size());
        for (int j = 0; j < exp_idx.size() && j < nfr; j++) begin
            a    = 7'(tbl_addr[exp_idx[j]]);
            d    = 9'(tbl_data[exp_idx[j]]);
            full = {7'h1A, 1'b0, a, d};
            expv = full >> (8 * (3 - exp_len[j]));
            check($sformatf("%s:fr%0d_len", name, j), fr_len[base_q + j], exp_len[j]);
            check($sformatf("%s:fr%0d_data", name, j), fr_data[base_q + j], expv);
        end
        nack_k = 0;
    endtask

    initial begin
        int off;
        repeat (3) @(negedge sys_clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_error", ack_error, 0);
        check("rst_cur_index", cur_index, 0);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        sys_rst = 1'b1;
        start   = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        start   = 1'b0;
        check("rst_wins_busy", busy, 0);
        @(negedge sys_clk);
        check("rst_wins_busy2", {busy, scl_oe, sda_oe}, 3'b000);

        run_case("full", 0, 0, 0, 1);
        run_case("nack_e2b1", 2, 1, 1, 0);
        run_case("nack_e3x2", 3, $urandom_range(0, 2), 2, 0);
        run_case("nack_rand", $urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(1, 4), 0);

        off = 5 * 264 + $urandom_range(10, 200);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (off - 1) @(negedge sys_clk);
        check("mid_index", cur_index, 5);
        check("mid_busy", busy, 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("mid_rst_lines", {scl_oe, sda_oe}, 2'b00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_index", cur_index, 0);
        check("mid_rst_done", {done, ack_error}, 2'b00);
        repeat (20) @(negedge sys_clk);
        check("mid_rst_quiet", {busy, scl_oe, sda_oe}, 3'b000);

        run_case("replay", 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
